// File: rtl/multicore_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicore_pkg
//  Description : Shared definitions for the multicore PLL supervisor slice.
//                State encoding visible on the debug port, default timing
//                constants and a small width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicore_pkg;

  // The encoding is exported on the debug port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_sup_state_t;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 4;
  localparam int unsigned DEF_LOSS_CNT_W          = 8;

  // Largest of three values; sizes the single shared cycle counter.
  function automatic int unsigned pll_sup_max3(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicore_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : multicore_sync2
//  Description : Generic two-flop synchronizer for level status bits that
//                cross into the clk domain. Both stages reset to 0.
//  Ports       : clk      - destination clock
//                reset_n  - asynchronous active-low reset
//                d_async  - input bits, asynchronous to clk
//                q_sync   - synchronized bits, two cycles of latency
//  Revision    : 1.0 - initial release
// ============================================================================
module multicore_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_async,
  output logic [WIDTH-1:0] q_sync
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_async;
      sync_q <= meta_q;
    end
  end

  assign q_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/multicore_pll_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : multicore_pll_supervisor
//  Description : Brings up the system PLL from the reference clock domain,
//                qualifies lock stability, releases the system reset, counts
//                lock losses and retries failed locks up to a bounded count
//                before latching a failure flag.
//  Ports       : clk         - free-running reference clock
//                reset_n     - asynchronous active-low reset
//                pll_locked  - PLL lock, asynchronous to clk
//                force_retry - one-cycle request to restart PLL bring-up
//                pll_rst     - active-high PLL reset
//                sys_reset_n - registered active-low system reset
//                pll_ok      - high only while in RUN
//                fail        - sticky failure flag
//                state       - current FSM encoding (debug)
//                loss_count  - saturating count of lock losses seen in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module multicore_pll_supervisor
  import multicore_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned LOSS_CNT_W          = DEF_LOSS_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_locked,
  input  logic                  force_retry,
  output logic                  pll_rst,
  output logic                  sys_reset_n,
  output logic                  pll_ok,
  output logic                  fail,
  output logic [2:0]            state,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  // One counter serves every timed state; it is cleared on each state entry.
  localparam int unsigned CNT_MAX = pll_sup_max3(RST_PULSE_CYCLES,
                                                 LOCK_TIMEOUT_CYCLES,
                                                 LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES) + 1;

  localparam logic [CNT_W-1:0]      RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]    RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_CNT_W-1:0] LOSS_SAT    = {LOSS_CNT_W{1'b1}};

  pll_sup_state_t        state_q,       state_d;
  logic [CNT_W-1:0]      cnt_q,         cnt_d;
  logic [RETRY_W-1:0]    retry_q,       retry_d;
  logic [LOSS_CNT_W-1:0] loss_q,        loss_d;
  logic                  pll_rst_q,     pll_rst_d;
  logic                  sys_reset_n_q, sys_reset_n_d;
  logic                  pll_ok_q,      pll_ok_d;
  logic                  fail_q,        fail_d;
  logic                  lk_s;
  logic [RETRY_W-1:0]    retry_inc;

  multicore_sync2 #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_async (pll_locked),
    .q_sync  (lk_s)
  );

  assign retry_inc = retry_q + RETRY_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    if (force_retry) begin
      // Software restart outranks everything, including a coincident lock
      // loss in RUN, which is therefore not counted.
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // A lock seen on the final timeout cycle still wins over the retry.
          if (lk_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d   = '0;
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // Any low cycle restarts qualification from WAIT_LOCK without
          // consuming a retry.
          if (!lk_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            if (loss_q != LOSS_SAT) begin
              loss_d = loss_q + LOSS_CNT_W'(1);
            end
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so the registered copies
    // change on the same edge as the state register.
    pll_rst_d     = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
    sys_reset_n_d = (state_d == ST_RUN);
    pll_ok_d      = (state_d == ST_RUN);
    fail_d        = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      loss_q        <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      pll_ok_q      <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      loss_q        <= loss_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      pll_ok_q      <= pll_ok_d;
      fail_q        <= fail_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign pll_ok      = pll_ok_q;
  assign fail        = fail_q;
  assign state       = state_q;
  assign loss_count  = loss_q;

endmodule
`default_nettype wire

// File: tb/tb_multicore_pll_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicore_pll_supervisor
//  Description : Self-checking bench for multicore_pll_supervisor. Expected
//                latencies are derived arithmetically from the timing rules
//                (synchronizer delay, pulse, timeout and stability lengths).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicore_pll_supervisor;

  localparam int unsigned RST_P   = 4;
  localparam int unsigned TMO     = 64;
  localparam int unsigned STB     = 16;
  localparam int unsigned MAXR    = 3;
  localparam int unsigned LW      = 3;
  localparam int unsigned LOSSMAX = (1 << LW) - 1;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned BUDGET  = 500;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pll_locked;
  logic          force_retry;
  logic          pll_rst;
  logic          sys_reset_n;
  logic          pll_ok;
  logic          fail;
  logic [2:0]    state;
  logic [LW-1:0] loss_count;

  int n_tests = 0;
  int n_fail  = 0;
  int loss_m  = 0;

  multicore_pll_supervisor #(
    .RST_PULSE_CYCLES    (RST_P),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .LOCK_STABLE_CYCLES  (STB),
    .MAX_RETRIES         (MAXR),
    .LOSS_CNT_W          (LW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .force_retry (force_retry),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .pll_ok      (pll_ok),
    .fail        (fail),
    .state       (state),
    .loss_count  (loss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until the selected output equals val (0 pll_rst, 1 sys_reset_n,
  // 2 state); returns BUDGET when the condition never appears.
  task automatic wait_sig(input int sel, input logic [2:0] val, output int n);
    logic [2:0] cur;
    n = 0;
    do begin
      tick();
      n++;
      case (sel)
        0:       cur = {2'b00, pll_rst};
        1:       cur = {2'b00, sys_reset_n};
        default: cur = state;
      endcase
    end while (cur !== val && n < BUDGET);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_sys_reset_n"}, sys_reset_n, 0);
    chk({tag, "_pll_ok"}, pll_ok, 0);
    chk({tag, "_fail"}, fail, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_loss"}, loss_count, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    int d;
    int bad_rst;
    int bad_fail;
    int bad_sys;
    logic exp_rst;

    reset_n     = 1'b0;
    pll_locked  = 1'b0;
    force_retry = 1'b0;
    repeat (3) tick();
    chk_reset_vals("por");

    // Initial bring-up, lock 10 cycles after pll_rst falls.
    reset_n = 1'b1;
    wait_sig(0, 3'd0, n);
    chk("pll_rst_pulse_len", n, RST_P);
    chk("wait_state", state, 1);
    repeat (10) tick();
    pll_locked = 1'b1;
    wait_sig(1, 3'd1, n);
    chk("lock_to_sysrst", n, SYNC + STB + 1);
    chk("run_pll_ok", pll_ok, 1);
    chk("run_state", state, 3);

    // Random lock glitches in RUN; loss counter saturates at LOSSMAX.
    for (int it = 0; it < 9; it++) begin
      repeat ($urandom_range(0, 5)) tick();
      g = $urandom_range(1, 3);
      pll_locked = 1'b0;
      n = 0;
      do begin
        tick();
        n++;
        if (n == g) pll_locked = 1'b1;
      end while (sys_reset_n !== 1'b0 && n < 20);
      chk("run_drop_latency", n, SYNC + 1);
      loss_m = (loss_m == LOSSMAX) ? LOSSMAX : loss_m + 1;
      chk("loss_count", loss_count, loss_m);
      chk("drop_state", state, 0);
      chk("drop_pll_ok", pll_ok, 0);
      wait_sig(1, 3'd1, n);
      chk("rebringup_len", n, RST_P + 1 + STB);
    end

    // Lock fall coincident with force_retry in RUN: no loss counted.
    pll_locked = 1'b0;
    tick();
    tick();
    force_retry = 1'b1;
    pll_locked  = 1'b1;
    tick();
    force_retry = 1'b0;
    chk("force_vs_loss_state", state, 0);
    chk("force_vs_loss_count", loss_count, loss_m);
    chk("force_sys_reset_n", sys_reset_n, 0);

    // Glitch in STABLE after 10 good cycles: back to WAIT_LOCK, requalify.
    wait_sig(2, 3'd2, n);
    chk("force_to_stable", n, RST_P + 1);
    repeat (10) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    wait_sig(2, 3'd1, n);
    chk("stable_drop_to_wait", n, 1);
    wait_sig(2, 3'd2, n);
    chk("wait_to_stable_again", n, 2);
    chk("stable_no_fail", fail, 0);
    wait_sig(2, 3'd3, n);
    chk("stable_count_restart", n, STB);

    // Lock never arrives: MAXR pulses separated by full timeouts, then FAIL.
    pll_locked  = 1'b0;
    force_retry = 1'b1;
    tick();
    force_retry = 1'b0;
    chk("fail_path_loss", loss_count, loss_m);
    bad_rst  = 0;
    bad_fail = 0;
    bad_sys  = 0;
    for (int i = 0; i < MAXR * (RST_P + TMO) + 16; i++) begin
      if (i > 0) tick();
      exp_rst = (i >= MAXR * (RST_P + TMO)) || ((i % (RST_P + TMO)) < RST_P);
      if (pll_rst !== exp_rst) bad_rst++;
      if (fail !== (i >= MAXR * (RST_P + TMO))) bad_fail++;
      if (sys_reset_n !== 1'b0) bad_sys++;
    end
    chk("retry_pll_rst_seq", bad_rst, 0);
    chk("retry_fail_timing", bad_fail, 0);
    chk("retry_sys_reset_low", bad_sys, 0);
    chk("fail_state", state, 4);
    chk("fail_flag", fail, 1);
    chk("fail_pll_rst", pll_rst, 1);

    // Recover from FAIL with force_retry.
    force_retry = 1'b1;
    pll_locked  = 1'b1;
    tick();
    force_retry = 1'b0;
    chk("recover_fail_clear", fail, 0);
    chk("recover_state", state, 0);
    wait_sig(1, 3'd1, n);
    chk("recover_to_run", n, RST_P + 1 + STB);
    chk("recover_loss", loss_count, loss_m);
    chk("recover_pll_ok", pll_ok, 1);

    // Asynchronous reset mid-RUN, no clock edge in between.
    reset_n = 1'b0;
    #2;
    loss_m = 0;
    chk_reset_vals("async_run");

    // Randomized lock arrival after reset release.
    for (int it = 0; it < 3; it++) begin
      pll_locked = 1'b0;
      reset_n    = 1'b0;
      tick();
      reset_n = 1'b1;
      wait_sig(0, 3'd0, n);
      chk("rand_pll_rst_len", n, RST_P);
      d = $urandom_range(0, TMO - 9);
      repeat (d) tick();
      pll_locked = 1'b1;
      wait_sig(1, 3'd1, n);
      chk("rand_lock_to_sysrst", n, SYNC + STB + 1);
    end

    // Asynchronous reset mid-STABLE.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    wait_sig(2, 3'd2, n);
    chk("rst_to_stable", n, RST_P + 1);
    repeat (5) tick();
    reset_n = 1'b0;
    #2;
    chk_reset_vals("async_stable");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicore_pll_supervisor.md
Name: multicore_pll_supervisor

Overview:
- Supervises the system PLL from the free-running 50 MHz reference domain.
- Drives the PLL reset and consumes the asynchronous PLL lock indication.
- Qualifies lock stability and releases a clean active-low system reset to the multicore fabric.
- Recovers from lock loss and retries failed locks, up to a bounded count, then latches a failure flag.

Parameters:
- RST_PULSE_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (min 1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles allowed in WAIT_LOCK before a retry is counted (min 2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before system reset release (min 1).
- MAX_RETRIES, 4: lock timeouts tolerated before entering FAIL (min 1).
- LOSS_CNT_W, 8: width of the saturating lock-loss counter.

Ports:
- clk  in  1  reference clock, free-running, same source as the PLL refclk.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL lock; asynchronous to clk.
- force_retry  in  1  single-cycle software request to restart PLL bring-up.
- pll_rst  out  1  active-high reset to the PLL.
- sys_reset_n  out  1  active-low reset to the system, registered.
- pll_ok  out  1  high only in RUN.
- fail  out  1  sticky failure flag.
- state  out  3  current FSM encoding, for debug.
- loss_count  out  LOSS_CNT_W  saturating count of lock losses seen in RUN.

Behaviour:
- Reset (reset_n low, async): state=RESET_PLL, pll_rst=1, sys_reset_n=0, pll_ok=0, fail=0, loss_count=0, all counters 0.
- pll_locked passes through a 2-FF synchronizer (lk_s). All decisions use lk_s, so lock-to-decision latency is 2 cycles.
- State encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- RESET_PLL:
  - pll_rst=1, cycle counter increments.
  - After RST_PULSE_CYCLES cycles, go to WAIT_LOCK and clear the counter.
- WAIT_LOCK:
  - pll_rst=0.
  - lk_s=1 → STABLE, counter cleared.
  - Counter reaching LOCK_TIMEOUT_CYCLES-1 with lk_s=0 → retry_cnt+1. If the new retry_cnt equals MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL.
- STABLE:
  - Counter increments while lk_s=1.
  - lk_s=0 → WAIT_LOCK with the timeout counter restarted. Not counted as a retry.
  - LOCK_STABLE_CYCLES consecutive lk_s=1 cycles → RUN, retry_cnt cleared.
- RUN:
  - sys_reset_n=1 and pll_ok=1, both registered; they rise on the first cycle the state register holds RUN.
  - lk_s=0 → next cycle sys_reset_n=0 and pll_ok=0, loss_count+1 (saturates at all-ones), go to RESET_PLL.
- FAIL:
  - fail=1, pll_rst=1 (PLL held in reset), sys_reset_n=0.
  - Exits only on reset_n or force_retry.
- sys_reset_n is 0 in every state except RUN.
- force_retry has priority over all other transitions, from any state including FAIL and RUN:
  - Next state RESET_PLL, retry_cnt=0, fail cleared, counters cleared.
  - loss_count is unchanged. A force_retry in RUN is not counted as a loss.
- Simultaneous lk_s fall and force_retry in RUN: force_retry wins and loss_count does not increment.
- Counters are sized $clog2 of their largest parameter plus 1. There are no wrap-around paths: every counter is cleared on each state entry.
- Glitch rule: a lk_s low pulse of at least 1 cycle in STABLE or RUN is always acted on. There is no filtering beyond the synchronizer.

Decomposition:
- Shared package multicore_pkg holds the state enum (3-bit typedef pll_sup_state_t) and the default timing constants.
- Sub-module multicore_sync2: generic 2-FF synchronizer with async active-low reset to 0. It is reused later for other CDC status bits.

Test Plan (RST_PULSE=4, LOCK_TIMEOUT=64, STABLE=16, MAX_RETRIES=3):
- Reset release, pll_locked rises 10 cycles after pll_rst falls → pll_rst high for exactly 4 cycles. sys_reset_n rises exactly 2+16+1 cycles after pll_locked rises. pll_ok=1, state=3.
- pll_locked never asserts → 3 pll_rst pulses of 4 cycles each, separated by 64-cycle waits, then state=4, fail=1, pll_rst=1, sys_reset_n stays 0 throughout.
- In RUN, drop pll_locked for 1 cycle → sys_reset_n low 3 cycles after the drop, loss_count=1, full re-bring-up, RUN re-entered.
- In STABLE after 10 good cycles, drop pll_locked for 2 cycles → return to WAIT_LOCK, stability count restarts from 0, retry_cnt unchanged, no fail.
- In FAIL, pulse force_retry, then assert pll_locked → fail clears the next cycle, normal bring-up reaches RUN, loss_count unchanged.
- Assert reset_n low mid-STABLE and mid-RUN → outputs take their reset values asynchronously (pll_rst=1, sys_reset_n=0) with no clock edge. loss_count returns to 0.
